// File: rtl/rcosc_tick_gen_if.sv
// Control/status bundle for rcosc_tick_gen: channel enables, divide-ratio writes, tick strobes.
// The master drives enables and writes; the slave (the tick generator) returns status and ticks.
interface rcosc_tick_gen_if #(
  parameter int unsigned NumCh = 4,
  parameter int unsigned DivW  = 16
);
  localparam int unsigned SelW = (NumCh > 1) ? $clog2(NumCh) : 1;

  logic [NumCh-1:0] ch_en;
  logic             div_wr;
  logic [SelW-1:0]  div_sel;
  logic [DivW-1:0]  div_val;
  logic             wr_err;
  logic             ready;
  logic [NumCh-1:0] tick;

  modport master (
    output ch_en, div_wr, div_sel, div_val,
    input  wr_err, ready, tick
  );

  modport slave (
    input  ch_en, div_wr, div_sel, div_val,
    output wr_err, ready, tick
  );
endinterface

// File: rtl/rcosc_tick_gen.sv
// Multi-channel clock-enable generator: waits out the oscillator settle interval, then emits
// per-channel single-cycle ticks with glitch-free run-time programmable divide ratios.
module rcosc_tick_gen #(
  parameter int unsigned NumCh        = 4,
  parameter int unsigned DivW         = 16,
  parameter int unsigned SettleCycles = 1024,
  parameter int unsigned DefaultDiv   = 160
) (
  input logic             clk,
  input logic             rst,
  rcosc_tick_gen_if.slave bus
);
  localparam int unsigned      SelW       = (NumCh > 1) ? $clog2(NumCh) : 1;
  localparam int unsigned      SettleW    = (SettleCycles > 1) ? $clog2(SettleCycles) : 1;
  localparam logic [SettleW-1:0] SettleLast = SettleW'(SettleCycles - 1);
  localparam logic [DivW-1:0]  DefDiv     = DivW'(DefaultDiv);

  typedef enum logic {StSettle, StRun} state_e;

  state_e                       state_q, state_d;
  logic [SettleW-1:0]           settle_cnt_q, settle_cnt_d;
  logic                         ready_q, ready_d;
  logic                         wr_err_q, wr_err_d;
  logic [NumCh-1:0]             tick_q, tick_d;
  logic [NumCh-1:0][DivW-1:0]   cnt_q, cnt_d;
  logic [NumCh-1:0][DivW-1:0]   active_q, active_d;
  logic [NumCh-1:0][DivW-1:0]   shadow_q, shadow_d;

  logic wr_ok;
  logic running;
  logic wrap;

  // Settle sequencer
  always_comb begin
    state_d      = state_q;
    settle_cnt_d = settle_cnt_q;
    ready_d      = ready_q;
    unique case (state_q)
      StSettle: begin
        if (settle_cnt_q == SettleLast) begin
          state_d = StRun;
          ready_d = 1'b1;
        end else begin
          settle_cnt_d = settle_cnt_q + 1'b1;
        end
      end
      StRun: ready_d = 1'b1;
      default: state_d = StSettle;
    endcase
  end

  // Channel counters and divisor handling
  always_comb begin
    wr_ok    = bus.div_wr && (bus.div_val != '0) && (32'(bus.div_sel) < NumCh);
    wr_err_d = bus.div_wr && !wr_ok;
    cnt_d    = cnt_q;
    active_d = active_q;
    shadow_d = shadow_q;
    tick_d   = '0;
    running  = 1'b0;
    wrap     = 1'b0;
    for (int i = 0; i < NumCh; i++) begin
      running = (state_q == StRun) && bus.ch_en[i];
      wrap    = running && (cnt_q[i] == active_q[i] - DivW'(1));
      if (wr_ok && (bus.div_sel == SelW'(i))) begin
        shadow_d[i] = bus.div_val;
      end
      cnt_d[i]  = (running && !wrap) ? cnt_q[i] + DivW'(1) : '0;
      tick_d[i] = wrap;
      // An idle channel takes the new ratio at once; a running one only at a period boundary.
      if (!running || wrap) begin
        active_d[i] = shadow_d[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StSettle;
      settle_cnt_q <= '0;
      ready_q      <= 1'b0;
      wr_err_q     <= 1'b0;
      tick_q       <= '0;
      cnt_q        <= '0;
      active_q     <= {NumCh{DefDiv}};
      shadow_q     <= {NumCh{DefDiv}};
    end else begin
      state_q      <= state_d;
      settle_cnt_q <= settle_cnt_d;
      ready_q      <= ready_d;
      wr_err_q     <= wr_err_d;
      tick_q       <= tick_d;
      cnt_q        <= cnt_d;
      active_q     <= active_d;
      shadow_q     <= shadow_d;
    end
  end

  assign bus.ready  = ready_q;
  assign bus.wr_err = wr_err_q;
  assign bus.tick   = tick_q;

endmodule
